// File: rtl/mux_bist_ctrl.sv
// mux_bist_ctrl: built-in self-test engine for a WIDTH-bit 2:1 select datapath.
// An LFSR produces A/B/sel vectors, which are driven out and held for one cycle.
// The returned Y is then compared against the registered expected value.
// Mismatches are counted, saturating at 255, and the first failing vector index is recorded.
module mux_bist_ctrl #(
    parameter int          WIDTH       = 4,
    parameter int          NUM_VECTORS = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             sel_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]  LAST_IDX = 8'(NUM_VECTORS - 1);
    localparam logic [15:0] LFSR_TAP = 16'hB400;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_start_run;
    logic [15:0]      r_lfsr;
    logic [15:0]      w_lfsr_next;
    logic [WIDTH-1:0] r_exp;
    logic [7:0]       r_vec_idx;
    logic [WIDTH-1:0] w_lfsr_a;
    logic [WIDTH-1:0] w_lfsr_b;
    logic             w_lfsr_sel;
    logic             w_mismatch;

    assign w_lfsr_a    = r_lfsr[WIDTH-1:0];
    assign w_lfsr_b    = r_lfsr[2*WIDTH-1:WIDTH];
    assign w_lfsr_sel  = r_lfsr[2*WIDTH];
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAP : 16'h0000);
    assign w_mismatch  = (y_in != r_exp);

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE or DONE, never mid-run.
    always_comb begin
        w_next_state = r_state;
        w_start_run  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_DRIVE;
                    w_start_run  = 1'b1;
                end
            end
            S_DRIVE: begin
                w_next_state = S_CHECK;
            end
            S_CHECK: begin
                if (r_vec_idx == LAST_IDX) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_DRIVE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next_state = S_DRIVE;
                    w_start_run  = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Vector generation, response checking and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr    <= LFSR_SEED;
            r_exp     <= '0;
            r_vec_idx <= 8'h00;
            a_out     <= '0;
            b_out     <= '0;
            sel_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'h00;
            fail_idx  <= 8'hFF;
        end else if (w_start_run) begin
            r_lfsr    <= LFSR_SEED;
            r_vec_idx <= 8'h00;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'h00;
            fail_idx  <= 8'hFF;
        end else begin
            case (r_state)
                S_DRIVE: begin
                    a_out   <= w_lfsr_a;
                    b_out   <= w_lfsr_b;
                    sel_out <= w_lfsr_sel;
                    r_exp   <= w_lfsr_sel ? w_lfsr_b : w_lfsr_a;
                    r_lfsr  <= w_lfsr_next;
                end
                S_CHECK: begin
                    // y_in has had a full cycle to settle since the stimulus changed.
                    if (w_mismatch) begin
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'h01;
                        end
                        if (fail_idx == 8'hFF) begin
                            fail_idx <= r_vec_idx;
                        end
                    end
                    if (r_vec_idx != LAST_IDX) begin
                        r_vec_idx <= r_vec_idx + 8'h01;
                    end
                end
                S_DONE: begin
                    // err_count is already final here, so pass sees the last vector's result.
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 8'h00);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// tb_mux_bist_ctrl: directed bench for mux_bist_ctrl with a selectable datapath stand-in.
module tb_mux_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] y_in;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       sel_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] fail_idx;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int mode     = 0;   // 0 golden mux, 1 stuck at zero, 2 inverted select

    logic [3:0] va [16];
    logic [3:0] vb [16];
    logic       vs [16];
    int exp_err_zero;
    int exp_fidx_zero;
    int exp_err_inv;

    mux_bist_ctrl #(.WIDTH(4), .NUM_VECTORS(16), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
        .a_out(a_out), .b_out(b_out), .sel_out(sel_out),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in selected by mode.
    always_comb begin
        y_in = 4'h0;
        case (mode)
            0: y_in = sel_out ? b_out : a_out;
            1: y_in = 4'h0;
            2: y_in = sel_out ? a_out : b_out;
            default: y_in = 4'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edge_n = 0;
    endtask

    task automatic run_until(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic build_model();
        logic [15:0] l;
        l = 16'hACE1;
        exp_err_zero  = 0;
        exp_fidx_zero = 255;
        exp_err_inv   = 0;
        for (int k = 0; k < 16; k++) begin
            va[k] = l[3:0];
            vb[k] = l[7:4];
            vs[k] = l[8];
            if ((vs[k] ? vb[k] : va[k]) != 4'h0) begin
                exp_err_zero++;
                if (exp_fidx_zero == 255) exp_fidx_zero = k;
            end
            if (va[k] != vb[k]) exp_err_inv++;
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #23;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_err got=%h exp=00", err_count); end
        checks++; if (fail_idx !== 8'hFF) begin failures++; $display("FAIL reset_fidx got=%h exp=FF", fail_idx); end
        checks++; if ({a_out, b_out, sel_out} !== 9'h000) begin failures++; $display("FAIL reset_stim got=%h/%h/%b exp=0/0/0", a_out, b_out, sel_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    // Golden run: first vectors, timing of done and a clean result.
    task automatic test_golden(input string tag);
        mode = 0;
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_start got=%b exp=1", tag, busy); end
        tick();
        checks++; if ({a_out, b_out, sel_out} !== {4'h1, 4'hE, 1'b0}) begin failures++; $display("FAIL %s_vec0 got=%h/%h/%b exp=1/e/0", tag, a_out, b_out, sel_out); end
        run_until(3);
        checks++; if ({a_out, b_out, sel_out} !== {4'h0, 4'h7, 1'b0}) begin failures++; $display("FAIL %s_vec1 got=%h/%h/%b exp=0/7/0", tag, a_out, b_out, sel_out); end
        run_until(32);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_early got=%b exp=0", tag, done); end
        run_until(33);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", tag, done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%b exp=0", tag, busy); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL %s_pass got=%b exp=1", tag, pass); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL %s_err got=%h exp=00", tag, err_count); end
        checks++; if (fail_idx !== 8'hFF) begin failures++; $display("FAIL %s_fidx got=%h exp=FF", tag, fail_idx); end
        checks++; if ({a_out, b_out, sel_out} !== {va[15], vb[15], vs[15]}) begin failures++; $display("FAIL %s_hold got=%h/%h/%b exp=%h/%h/%b", tag, a_out, b_out, sel_out, va[15], vb[15], vs[15]); end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_done_held got=%b exp=1", tag, done); end
    endtask

    task automatic test_stuck_zero();
        mode = 1;
        pulse_start();
        run_until(33);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL zero_pass got=%b exp=0", pass); end
        checks++; if (err_count !== 8'(exp_err_zero)) begin failures++; $display("FAIL zero_err got=%0d exp=%0d", err_count, exp_err_zero); end
        checks++; if (fail_idx !== 8'h00) begin failures++; $display("FAIL zero_fidx got=%h exp=00", fail_idx); end
        checks++; if (fail_idx !== 8'(exp_fidx_zero)) begin failures++; $display("FAIL zero_fidx_model got=%h exp=%h", fail_idx, exp_fidx_zero); end
    endtask

    task automatic test_inverted_sel();
        mode = 2;
        pulse_start();
        run_until(33);
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL inv_pass got=%b exp=0", pass); end
        checks++; if (err_count !== 8'(exp_err_inv)) begin failures++; $display("FAIL inv_err got=%0d exp=%0d", err_count, exp_err_inv); end
        checks++; if (fail_idx !== 8'h00) begin failures++; $display("FAIL inv_fidx got=%h exp=00", fail_idx); end
    endtask

    task automatic test_start_while_busy();
        mode = 0;
        pulse_start();
        run_until(2);
        start = 1'b1; tick(); start = 1'b0;
        run_until(9);
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_ign_busy got=%b exp=1", busy); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL busy_ign_err got=%h exp=00", err_count); end
        run_until(32);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL busy_ign_early got=%b exp=0", done); end
        run_until(33);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL busy_ign_done got=%b exp=1", done); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL busy_ign_pass got=%b exp=1", pass); end
        checks++; if (fail_idx !== 8'hFF) begin failures++; $display("FAIL busy_ign_fidx got=%h exp=FF", fail_idx); end
    endtask

    task automatic test_reset_midrun();
        mode = 1;
        pulse_start();
        run_until(11);
        checks++; if (err_count === 8'h00) begin failures++; $display("FAIL mid_err_before got=%h exp=nonzero", err_count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL mid_err got=%h exp=00", err_count); end
        checks++; if (fail_idx !== 8'hFF) begin failures++; $display("FAIL mid_fidx got=%h exp=FF", fail_idx); end
        checks++; if (a_out !== 4'h0) begin failures++; $display("FAIL mid_a got=%h exp=0", a_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_golden("rerun");
    endtask

    task automatic test_back_to_back();
        mode = 2;
        pulse_start();
        run_until(33);
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL b2b_first_pass got=%b exp=0", pass); end
        mode = 0;
        pulse_start();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_clr got=%b exp=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL b2b_pass_clr got=%b exp=0", pass); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL b2b_err_clr got=%h exp=00", err_count); end
        checks++; if (fail_idx !== 8'hFF) begin failures++; $display("FAIL b2b_fidx_clr got=%h exp=FF", fail_idx); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        run_until(33);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL b2b_pass got=%b exp=1", pass); end
    endtask

    initial begin
        build_model();
        test_reset();
        test_golden("golden");
        test_stuck_zero();
        test_inverted_sel();
        test_start_while_busy();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
